// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, starvation limit and state/requester encodings for the memory arbiter.
package mem_arb_pkg;
    localparam int ADDR_W       = 64;
    localparam int DATA_W       = 64;
    localparam int INSTR_W      = 80;
    localparam int STARVE_LIMIT = 4;
    typedef enum logic {S_IDLE, S_ACCESS} state_e;
    typedef enum logic {REQ_IF, REQ_DM} req_id_e;
endpackage

// File: rtl/arb_starve_cnt.sv
// arb_starve_cnt: saturating count of data grants taken while a fetch waits; flags when fetch must win.
module arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic if_req_i,
    input  logic if_gnt_i,
    input  logic dm_gnt_i,
    output logic force_fetch_o
);
    localparam int CW = $clog2(LIMIT + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb cnt_d = (!if_req_i || if_gnt_i) ? '0 :
                        (dm_gnt_i && cnt_q != CW'(LIMIT)) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk_i)
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    assign force_fetch_o = if_req_i && cnt_q == CW'(LIMIT);
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: single-port RAM shared by instruction fetch and data requesters, data-first with
// anti-starvation; grant at N, RAM access at N+1, registered response pulse at N+2.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int LIMIT = STARVE_LIMIT
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               if_req_i,
    input  logic [ADDR_W-1:0]  if_addr_i,
    output logic               if_gnt_o,
    output logic               if_rvalid_o,
    output logic [INSTR_W-1:0] if_rdata_o,
    output logic               if_err_o,
    input  logic               dm_req_i,
    input  logic               dm_we_i,
    input  logic [ADDR_W-1:0]  dm_addr_i,
    input  logic [DATA_W-1:0]  dm_wdata_i,
    output logic               dm_gnt_o,
    output logic               dm_rvalid_o,
    output logic [DATA_W-1:0]  dm_rdata_o,
    output logic               dm_err_o,
    output logic               ram_read_en_o,
    output logic               ram_write_en_o,
    output logic               ram_read_instruction_en_o,
    output logic [ADDR_W-1:0]  ram_addr_o,
    output logic [DATA_W-1:0]  ram_write_data_o,
    input  logic [DATA_W-1:0]  ram_read_data_i,
    input  logic [INSTR_W-1:0] ram_read_instruction_i,
    input  logic               ram_error_i
);
    state_e             state_q, state_d;
    req_id_e            id_q;
    logic               we_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]  wdata_q;
    logic               if_rvalid_q, if_err_q, dm_rvalid_q, dm_err_q;
    logic [INSTR_W-1:0] if_rdata_q;
    logic [DATA_W-1:0]  dm_rdata_q;
    logic               force_fetch, acc, is_if, wr;

    arb_starve_cnt #(.LIMIT(LIMIT)) u_starve (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .if_req_i      (if_req_i),
        .if_gnt_i      (if_gnt_o),
        .dm_gnt_i      (dm_gnt_o),
        .force_fetch_o (force_fetch)
    );

    assign dm_gnt_o = ~rst_i & dm_req_i & ~force_fetch;
    assign if_gnt_o = ~rst_i & if_req_i & ~dm_gnt_o;
    assign state_d  = (if_gnt_o | dm_gnt_o) ? S_ACCESS : S_IDLE;
    // RAM controls come from the latched request, but reset must cut an in-flight access immediately
    assign acc   = ~rst_i & (state_q == S_ACCESS);
    assign is_if = id_q == REQ_IF;
    assign wr    = acc & ~is_if & we_q;
    assign ram_addr_o                = acc ? addr_q : '0;
    assign ram_read_en_o             = acc & (is_if | ~we_q);
    assign ram_read_instruction_en_o = acc & is_if;
    assign ram_write_en_o            = wr & ~ram_error_i;
    assign ram_write_data_o          = wr ? wdata_q : '0;

    always_ff @(posedge clk_i)
        if (rst_i) begin
            state_q     <= S_IDLE;
            id_q        <= REQ_IF;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            if_rvalid_q <= 1'b0;
            if_err_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rvalid_q <= 1'b0;
            dm_err_q    <= 1'b0;
            dm_rdata_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_d == S_ACCESS) begin
                id_q    <= dm_gnt_o ? REQ_DM : REQ_IF;
                we_q    <= dm_gnt_o & dm_we_i;
                addr_q  <= dm_gnt_o ? dm_addr_i : if_addr_i;
                wdata_q <= dm_wdata_i;
            end
            if_rvalid_q <= acc & is_if;
            if_err_q    <= acc & is_if & ram_error_i;
            if_rdata_q  <= (acc & is_if & ~ram_error_i) ? ram_read_instruction_i : '0;
            dm_rvalid_q <= acc & ~is_if;
            dm_err_q    <= acc & ~is_if & ram_error_i;
            dm_rdata_q  <= (acc & ~is_if & ~we_q & ~ram_error_i) ? ram_read_data_i : '0;
        end

    assign if_rvalid_o = if_rvalid_q & ~rst_i;
    assign if_err_o    = if_err_q & ~rst_i;
    assign if_rdata_o  = rst_i ? '0 : if_rdata_q;
    assign dm_rvalid_o = dm_rvalid_q & ~rst_i;
    assign dm_err_o    = dm_err_q & ~rst_i;
    assign dm_rdata_o  = rst_i ? '0 : dm_rdata_q;
endmodule
